// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point helpers and default geometry for the CNN layer engines.
package cnn_fixed_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned LANES_DEF  = 16;
    localparam int unsigned IN_CH_DEF  = 64;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned SAT_W      = 64;

    function automatic int unsigned beats_of(input int unsigned in_ch, input int unsigned lanes);
        return in_ch / lanes;
    endfunction

    // Round-half-up by 'frac' bits, then clamp to a signed 'width'-bit range.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             frac,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        half = (frac == 0) ? '0 : (SAT_W'(1) << (frac - 1));
        r    = (acc + half) >>> frac;
        hi   = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        lo   = ~hi;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv2d1x1_acc_pipe_adder_tree.sv
// Combinational signed reduction of N packed IN_W-bit operands; the parent registers the sum.
module adder_tree_signed #(
    parameter  int unsigned IN_W  = 32,
    parameter  int unsigned N     = 16,
    localparam int unsigned OUT_W = IN_W + $clog2(N)
) (
    input  logic [N*IN_W-1:0] in_i,
    output logic [OUT_W-1:0]  sum_o
);

    logic signed [OUT_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum_c = sum_c + OUT_W'($signed(in_i[i*IN_W +: IN_W]));
        end
    end

    assign sum_o = sum_c;

endmodule

// File: rtl/conv2d1x1_acc_pipe.sv
// Pointwise (1x1) convolution for one output channel: multiply, tree-sum, accumulate, round/saturate.
// Define CONV1X1_RELU_EN to clamp negative outputs to zero.
module conv2d1x1_acc_pipe
    import cnn_fixed_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned IN_CH  = IN_CH_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [LANES*DATA_W-1:0] i_img,
    input  logic [LANES*DATA_W-1:0] i_kernel,
    input  logic [DATA_W-1:0]       i_bias,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_valid,
    output logic                    o_busy
);

    localparam int unsigned BEATS = beats_of(IN_CH, LANES);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned SUM_W = P_W + $clog2(LANES);

    if ((IN_CH % LANES) != 0) begin : g_bad_in_ch
        $error("IN_CH must be a multiple of LANES");
    end
    if ((ACC_W < 2 * DATA_W + $clog2(IN_CH) + 1) || (ACC_W > SAT_W)) begin : g_bad_acc_w
        $error("ACC_W out of range");
    end

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     beat_first_c, beat_last_c;

    logic [LANES*P_W-1:0]     prod_d;
    logic [LANES*P_W-1:0]     s1_prod_q;
    logic [DATA_W-1:0]        s1_bias_q;
    logic                     s1_valid_q, s1_first_q, s1_last_q;

    logic [SUM_W-1:0]         tree_sum;
    logic signed [ACC_W-1:0]  s2_sum_q, s2_sum_d;
    logic [DATA_W-1:0]        s2_bias_q;
    logic                     s2_valid_q, s2_first_q, s2_last_q;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     s3_valid_q, s3_last_q;

    logic [DATA_W-1:0]        data_q, data_d;
    logic                     valid_q, valid_d;

    adder_tree_signed #(
        .IN_W (P_W),
        .N    (LANES)
    ) u_tree (
        .in_i  (s1_prod_q),
        .sum_o (tree_sum)
    );

    // Beat tracking, per-lane products and the accumulate/round datapath.
    always_comb begin
        beat_first_c = (cnt_q == '0);
        beat_last_c  = (cnt_q == CNT_W'(BEATS - 1));
        cnt_d        = cnt_q;
        if (i_valid) begin
            cnt_d = beat_last_c ? '0 : cnt_q + CNT_W'(1);
        end
        busy_d = (cnt_d != '0);

        prod_d = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            prod_d[k*P_W +: P_W] = P_W'($signed(i_img[k*DATA_W +: DATA_W]))
                                 * P_W'($signed(i_kernel[k*DATA_W +: DATA_W]));
        end

        s2_sum_d = ACC_W'($signed(tree_sum));

        // Bias is shifted up to the 2*FRAC_W product scale before joining the sum.
        acc_d = acc_q;
        if (s2_valid_q) begin
            acc_d = s2_first_q ? s2_sum_q + (ACC_W'($signed(s2_bias_q)) <<< FRAC_W)
                               : acc_q + s2_sum_q;
        end

        data_d  = data_q;
        valid_d = s3_valid_q && s3_last_q;
        if (valid_d) begin
            data_d = DATA_W'(sat_round(SAT_W'(acc_q), FRAC_W, DATA_W));
`ifdef CONV1X1_RELU_EN
            if (data_d[DATA_W-1]) begin
                data_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            s1_prod_q  <= '0;
            s1_bias_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_sum_q   <= '0;
            s2_bias_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_prod_q  <= prod_d;
                s1_bias_q  <= i_bias;
                s1_first_q <= beat_first_c;
                s1_last_q  <= beat_last_c;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q   <= s2_sum_d;
                s2_bias_q  <= s1_bias_q;
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
            end
            acc_q      <= acc_d;
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_last_q <= s2_last_q;
            end
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;

endmodule
